cp0_timer_int: RTL and testbench
================================

# cp0_timer_int

Interrupt front-end for the CP0 unit. It synchronises external hardware interrupt lines and implements the CP0 Count (reg 9) and Compare (reg 11) timer pair. Its 6-bit `int_o` drives the CP0 register block's `int_i`, which is latched into Cause[15:10]. The CP0 read/write port is shared with the MEM-stage CP0 access bus, so `mtc0`/`mfc0` to regs 9 and 11 land here.

## Interface
Parameters:
- `EXT_INT_W`, 5: number of external hardware interrupt lines; they map to `int_o[4:0]`.
- `SYNC_STAGES`, 2: flip-flop depth of the per-line synchroniser; must be 2 or more.
- `COUNT_DIV`, 2: number of clock cycles per Count increment; must be 1 or more.

Ports:
- `cpu_clk_50M`  in  1  — system clock; the only clock.
- `cpu_rst`  in  1  — reset; synchronous, active-high.
- `ext_int_i`  in  EXT_INT_W  — asynchronous level-high external interrupt requests.
- `we`  in  1  — CP0 write enable from MEM.
- `waddr`  in  5  — CP0 write register number.
- `wdata`  in  32  — CP0 write data.
- `re`  in  1  — CP0 read enable.
- `raddr`  in  5  — CP0 read register number.
- `data_o`  out  32  — read data for Count/Compare; 0 otherwise.
- `hit_o`  out  1  — `re` is high and `raddr` is 9 or 11; the outer read mux selects `data_o` on this.
- `int_o`  out  6  — `[4:0]` are the synchronised external lines; `[5]` is the timer interrupt pending flag.
- `timer_int_o`  out  1  — copy of `int_o[5]`.

## Operation
**Synchroniser**
- Each `ext_int_i` bit passes through its own `SYNC_STAGES`-deep flop chain.
- `int_o[4:0]` is the last stage. Levels pass through with no latching and no edge detection.

**Prescaler**
- `div` counts 0 to `COUNT_DIV`-1 and wraps.
- Count increments in the cycle where `div` equals `COUNT_DIV`-1.
- Count wraps from 0xFFFF_FFFF to 0. No flag is raised on wrap.

**Count write**
- Condition: `we` is high and `waddr` is 9.
- Effect: `Count <= wdata` and `div <= 0`.
- A write beats an increment in the same cycle.

**Compare write**
- Condition: `we` is high and `waddr` is 11.
- Effect: `Compare <= wdata`, `cmp_armed <= 1`, `pending <= 0`.

**Match**
- When `cmp_armed` is 1 and the registered Count equals the registered Compare, `pending <= 1` on that edge.
- `pending` is sticky. Only a Compare write or reset clears it.
- A Compare write in the same cycle as a match wins: `pending` ends at 0.
- A Count write in the same cycle as a match: the match is evaluated on the pre-write Count, so `pending` sets.

**Read path**
- Combinational, with no write bypass.
- `data_o` is Count when `re` is high and `raddr` is 9, Compare when `re` is high and `raddr` is 11, and 0 otherwise.
- A read and a write to the same register in the same cycle return the old value.

**Other addresses**
- Writes to any `waddr` other than 9 or 11 are ignored here.

**Reset values**
- Synchroniser flops 0, `div` 0, Count 0, Compare 0, `cmp_armed` 0, `pending` 0.
- Therefore `int_o` = 0, `timer_int_o` = 0, and `data_o` and `hit_o` follow the read rules above.
- Reset mid-count discards everything and restarts from these values. A cleared `cmp_armed` prevents a spurious match at Count = Compare = 0.

## Timing
- External line to `int_o[i]`: `SYNC_STAGES` rising edges after the first edge that samples it high. Deassertion has the same latency.
- First Count increment after reset release: Count reads 1 in the cycle following the `COUNT_DIV`-th edge after reset deasserts. With the default, Count equals 1 after 2 cycles and N after 2N cycles.
- Count write: the new value is visible on `data_o` the cycle after the write. The next increment follows `COUNT_DIV` cycles after the write edge.
- Timer interrupt: `int_o[5]` rises on the edge after the cycle in which Count equals Compare is visible, i.e. one cycle of latency.
- Downstream, Cause[15] reflects `int_o[5]` one more cycle later.
- Compare write: `int_o[5]` falls the cycle after the write edge.
- Reads have zero latency; `data_o` and `hit_o` are combinational from `re` and `raddr`.

## Test plan
- Reset then idle 20 cycles with default parameters:
  - Count reads 10.
  - `int_o` = 6'b0 throughout, even though Compare = Count = 0 at reset.
- Write Compare = 5 at cycle 0 after reset:
  - `int_o[5]` = 0 until Count reaches 5 (cycle 10).
  - `int_o[5]` = 1 from cycle 11 and stays 1 for 50 more cycles.
  - Write Compare = 100: `int_o[5]` = 0 on the next cycle.
- Write Count = 0xFFFF_FFFE:
  - Count reads 0xFFFF_FFFF after 2 cycles and 0x0000_0000 after 4.
  - Compare = 0 (armed) gives `int_o[5]` = 1 one cycle after the wrap.
- Same-cycle Compare write and match (Count = Compare = 7, write Compare = 7):
  - `int_o[5]` stays 0.
  - A match later sets it after the next full wrap or after a Count rewrite to 6.
- Pulse `ext_int_i[2]` high for 3 cycles:
  - `int_o[2]` is high for exactly 3 cycles, starting 2 cycles later.
  - Other bits stay 0.
- Read checks:
  - `re` = 1, `raddr` = 9 gives `hit_o` = 1 and `data_o` = Count.
  - `raddr` = 12 gives `hit_o` = 0 and `data_o` = 0.
  - Same-cycle write of Count = 0x1234 with `raddr` = 9 returns the old Count, then 0x1234 on the next cycle.
  - Assert `cpu_rst` mid-count: all values return to their reset values on the next edge.

Source files
------------

// File: rtl/cp0_timer_int.sv
// CP0 interrupt front-end: external interrupt synchronisers plus the Count/Compare timer pair.
// int_o feeds Cause[15:10]; [5] is the sticky timer-pending flag.
module cp0_timer_int #(
    parameter int EXT_INT_W   = 5,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_DIV   = 2
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic [EXT_INT_W-1:0] ext_int_i,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [31:0]          wdata,
    input  logic                 re,
    input  logic [4:0]           raddr,
    output logic [31:0]          data_o,
    output logic                 hit_o,
    output logic [5:0]           int_o,
    output logic                 timer_int_o
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [EXT_INT_W-1:0] r_sync [SYNC_STAGES];
    logic [DIV_W-1:0]     r_div;
    logic [31:0]          r_count;
    logic [31:0]          r_compare;
    logic                 r_armed;
    logic                 r_pending;

    logic                 w_tick;
    logic                 w_count_we;
    logic                 w_compare_we;
    logic                 w_match;
    logic [4:0]           w_ext_int;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= ext_int_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_ext_int    = 5'(r_sync[SYNC_STAGES-1]);
    assign w_tick       = (r_div == DIV_LAST);
    assign w_count_we   = we && (waddr == REG_COUNT);
    assign w_compare_we = we && (waddr == REG_COMPARE);
    // Match uses the registered Count, so a same-cycle Count write cannot hide it.
    assign w_match      = r_armed && (r_count == r_compare);

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_div   <= '0;
            r_count <= '0;
        end else if (w_count_we) begin
            r_div   <= '0;
            r_count <= wdata;
        end else if (w_tick) begin
            r_div   <= '0;
            r_count <= r_count + 32'd1;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // Compare write clears pending even when a match occurs in the same cycle.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_compare <= '0;
            r_armed   <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_compare_we) begin
            r_compare <= wdata;
            r_armed   <= 1'b1;
            r_pending <= 1'b0;
        end else if (w_match) begin
            r_pending <= 1'b1;
        end
    end

    always_comb begin
        data_o = '0;
        hit_o  = re && ((raddr == REG_COUNT) || (raddr == REG_COMPARE));
        if (re) begin
            if (raddr == REG_COUNT) begin
                data_o = r_count;
            end else if (raddr == REG_COMPARE) begin
                data_o = r_compare;
            end
        end
    end

    assign int_o       = {r_pending, w_ext_int};
    assign timer_int_o = r_pending;

endmodule

// File: tb/tb_cp0_timer_int.sv
// Self-checking bench for cp0_timer_int: vectors pushed to a scoreboard queue, checked each cycle.
module tb_cp0_timer_int;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic [4:0]  ext_int_i;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  raddr;
    logic [31:0] data_o;
    logic        hit_o;
    logic [5:0]  int_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    cp0_timer_int dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (cpu_rst),
        .ext_int_i   (ext_int_i),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re          (re),
        .raddr       (raddr),
        .data_o      (data_o),
        .hit_o       (hit_o),
        .int_o       (int_o),
        .timer_int_o (timer_int_o)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re;
        logic [4:0]  raddr;
        logic [4:0]  ext;
        logic [31:0] exp_data;
        logic        exp_hit;
        logic [5:0]  exp_int;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd, input logic r, input logic [4:0] ra,
                                input logic [4:0] ext, input logic [31:0] ed, input logic eh,
                                input logic [5:0] ei);
        vec_t v;
        v.rst = rst; v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.raddr = ra;
        v.ext = ext; v.exp_data = ed; v.exp_hit = eh; v.exp_int = ei;
        return v;
    endfunction

    function automatic vec_t rd(input logic [4:0] ra, input logic [31:0] ed, input logic [5:0] ei);
        return mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ra, 5'd0, ed, 1'b1, ei);
    endfunction

    task automatic check_front(input string tag, input int idx);
        vec_t e;
        e = sb.pop_front();
        checks++;
        if (data_o !== e.exp_data) begin
            errors++;
            $display("FAIL %s[%0d] data_o got %h exp %h", tag, idx, data_o, e.exp_data);
        end
        checks++;
        if (hit_o !== e.exp_hit) begin
            errors++;
            $display("FAIL %s[%0d] hit_o got %b exp %b", tag, idx, hit_o, e.exp_hit);
        end
        checks++;
        if (int_o !== e.exp_int) begin
            errors++;
            $display("FAIL %s[%0d] int_o got %h exp %h", tag, idx, int_o, e.exp_int);
        end
        checks++;
        if (timer_int_o !== e.exp_int[5]) begin
            errors++;
            $display("FAIL %s[%0d] timer_int_o got %b exp %b", tag, idx, timer_int_o,
                     e.exp_int[5]);
        end
    endtask

    // Called at a falling edge: drive, check the combinational/registered view, advance.
    task automatic cyc(input vec_t v, input string tag, input int idx);
        cpu_rst   = v.rst;
        we        = v.we;
        waddr     = v.waddr;
        wdata     = v.wdata;
        re        = v.re;
        raddr     = v.raddr;
        ext_int_i = v.ext;
        sb.push_back(v);
        #1;
        check_front(tag, idx);
        @(negedge clk);
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re = 1'b0; raddr = '0; ext_int_i = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Read path, same-cycle write/read, sync reset mid-count.
        tbl[0]  = rd(5'd9, 32'd0, 6'h00);
        tbl[1]  = mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 6'h00);
        tbl[2]  = mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd0, 32'd0, 1'b0, 6'h00);
        tbl[3]  = mk(1'b0, 1'b1, 5'd11, 32'd2, 1'b1, 5'd11, 5'd0, 32'd0, 1'b1, 6'h00);
        tbl[4]  = rd(5'd11, 32'd2, 6'h00);
        tbl[5]  = mk(1'b0, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd9, 5'd0, 32'd2, 1'b1, 6'h20);
        tbl[6]  = mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'h1f, 32'h1234, 1'b1, 6'h20);
        tbl[7]  = mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'h1f, 32'h1234, 1'b1, 6'h20);
        tbl[8]  = mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'h00, 32'h1235, 1'b1, 6'h3f);
        tbl[9]  = rd(5'd9, 32'd0, 6'h00);
        tbl[10] = rd(5'd11, 32'd0, 6'h00);
        tbl[11] = rd(5'd9, 32'd1, 6'h00);

        // Idle after reset: Count advances every 2 cycles, no timer interrupt.
        do_reset();
        for (int k = 0; k <= 20; k++) cyc(rd(5'd9, 32'(k / 2), 6'h00), "idle", k);

        // Compare = 5, sticky pending, cleared by Compare rewrite.
        do_reset();
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd5, 1'b1, 5'd11, 5'd0, 32'd0, 1'b1, 6'h00), "cmp5", 0);
        for (int k = 1; k <= 61; k++)
            cyc(rd(5'd9, 32'(k / 2), (k >= 11) ? 6'h20 : 6'h00), "cmp5", k);
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd100, 1'b1, 5'd11, 5'd0, 32'd5, 1'b1, 6'h20), "cmp5", 62);
        cyc(rd(5'd11, 32'd100, 6'h00), "cmp5", 63);

        // Wrap: Compare = 0, Count = 0xFFFF_FFFE.
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd0, 1'b1, 5'd9, 5'd0, 32'd32, 1'b1, 6'h00), "wrap", 64);
        cyc(mk(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFE, 1'b1, 5'd9, 5'd0, 32'd32, 1'b1, 6'h00),
            "wrap", 65);
        for (int k = 66; k <= 72; k++)
            cyc(rd(5'd9, 32'hFFFF_FFFE + 32'((k - 66) / 2), (k >= 71) ? 6'h20 : 6'h00),
                "wrap", k);

        // Compare write coinciding with match wins; later match via Count rewrite to 6.
        do_reset();
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd7, 1'b1, 5'd11, 5'd0, 32'd0, 1'b1, 6'h00), "same", 0);
        for (int k = 1; k <= 13; k++) cyc(rd(5'd9, 32'(k / 2), 6'h00), "same", k);
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd7, 1'b1, 5'd9, 5'd0, 32'd7, 1'b1, 6'h00), "same", 14);
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd7, 1'b1, 5'd9, 5'd0, 32'd7, 1'b1, 6'h00), "same", 15);
        cyc(rd(5'd9, 32'd8, 6'h00), "same", 16);
        cyc(rd(5'd9, 32'd8, 6'h00), "same", 17);
        cyc(mk(1'b0, 1'b1, 5'd9, 32'd6, 1'b1, 5'd9, 5'd0, 32'd9, 1'b1, 6'h00), "same", 18);
        cyc(rd(5'd9, 32'd6, 6'h00), "same", 19);
        cyc(rd(5'd9, 32'd6, 6'h00), "same", 20);
        cyc(rd(5'd9, 32'd7, 6'h00), "same", 21);
        cyc(rd(5'd9, 32'd7, 6'h20), "same", 22);
        cyc(rd(5'd9, 32'd8, 6'h20), "same", 23);

        // Count write in the match cycle: match still seen on old Count.
        do_reset();
        cyc(mk(1'b0, 1'b1, 5'd11, 32'd3, 1'b1, 5'd11, 5'd0, 32'd0, 1'b1, 6'h00), "cntw", 0);
        for (int k = 1; k <= 5; k++) cyc(rd(5'd9, 32'(k / 2), 6'h00), "cntw", k);
        cyc(mk(1'b0, 1'b1, 5'd9, 32'd100, 1'b1, 5'd9, 5'd0, 32'd3, 1'b1, 6'h00), "cntw", 6);
        cyc(rd(5'd9, 32'd100, 6'h20), "cntw", 7);
        cyc(rd(5'd9, 32'd100, 6'h20), "cntw", 8);

        // ext_int_i[2] pulse of 3 cycles appears 2 cycles later.
        do_reset();
        for (int k = 0; k <= 6; k++)
            cyc(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, (k <= 2) ? 5'b00100 : 5'b00000,
                   32'(k / 2), 1'b1, (k >= 2 && k <= 4) ? 6'h04 : 6'h00), "ext", k);

        do_reset();
        for (int i = 0; i < 12; i++) cyc(tbl[i], "tbl", i);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
